// File: rtl/bus_rdata_muxn_pkg.sv
// Shared definitions for the N-channel read-data return mux:
// FSM state encodings, skid buffer depth and the select-width helper.
package bus_rdata_muxn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUTE = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // Number of entries in the output skid buffer (also its "full" count value).
    localparam logic [1:0] SKID_DEPTH = 2'd2;

    // Width of a channel select; a single bit is kept even for degenerate counts.
    function automatic int sel_width(input int num_ch);
        if (num_ch > 1) begin
            return $clog2(num_ch);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/bus_rdata_muxn_skid_buf.sv
// mux_skid_buf: 2-entry buffer of {err,last,data} beats feeding the master.
// The head entry is a flop that drives the outputs directly, so a beat pushed
// in cycle n is presented in cycle n+1 and stays frozen until it is popped.
module mux_skid_buf
    import bus_rdata_muxn_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  push_last,
    input  logic                  push_err,
    input  logic                  pop,
    output logic [1:0]            count,
    output logic                  head_valid,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic                  head_last,
    output logic                  head_err
);

    localparam int EW = DATA_WIDTH + 2;

    logic [EW-1:0] head_r;
    logic [EW-1:0] tail_r;
    logic [EW-1:0] push_word_s;
    logic [1:0]    count_r;
    logic [1:0]    count_nxt_s;
    logic          valid_r;

    assign push_word_s = {push_err, push_last, push_data};

    // Occupancy update: push and pop together leave the count unchanged.
    always_comb begin
        count_nxt_s = count_r;
        case ({push, pop})
            2'b10:   count_nxt_s = count_r + 2'd1;
            2'b01:   count_nxt_s = count_r - 2'd1;
            default: count_nxt_s = count_r;
        endcase
    end

    // Entry storage: the head only moves on a pop, so it holds under backpressure.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= 2'd0;
            valid_r <= 1'b0;
        end else begin
            count_r <= count_nxt_s;
            valid_r <= (count_nxt_s != 2'd0);
            case ({push, pop})
                2'b10: begin
                    if (count_r == 2'd0) begin
                        head_r <= push_word_s;
                    end else begin
                        tail_r <= push_word_s;
                    end
                end
                2'b01: begin
                    if (count_r == SKID_DEPTH) begin
                        head_r <= tail_r;
                    end else begin
                        head_r <= head_r;
                    end
                end
                2'b11: begin
                    if (count_r == SKID_DEPTH) begin
                        head_r <= tail_r;
                        tail_r <= push_word_s;
                    end else begin
                        head_r <= push_word_s;
                    end
                end
                default: begin
                    head_r <= head_r;
                end
            endcase
        end
    end

    assign count      = count_r;
    assign head_valid = valid_r;
    assign head_data  = head_r[DATA_WIDTH-1:0];
    assign head_last  = head_r[DATA_WIDTH];
    assign head_err   = head_r[DATA_WIDTH+1];

endmodule

// File: rtl/bus_rdata_muxn.sv
// bus_rdata_muxn: registered, handshaked, burst-aware N:1 read-data return mux.
// One select per transaction is taken from the address decoder; the chosen
// slave's burst is routed through a 2-entry skid buffer and the select is
// released only once the last beat has left the buffer.
// Optional feature macro: BUS_MUX_TIMEOUT_EN (idle timeout producing an error beat).
module bus_rdata_muxn
    import bus_rdata_muxn_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_CH         = 3,
    parameter int SEL_W          = sel_width(NUM_CH),
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [SEL_W-1:0]             sel,
    input  logic                         sel_valid,
    output logic                         sel_ready,
    input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_CH-1:0]            in_valid,
    input  logic [NUM_CH-1:0]            in_last,
    output logic [NUM_CH-1:0]            in_ready,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic                         out_valid,
    output logic                         out_last,
    output logic                         out_err,
    input  logic                         out_ready
);

    if (NUM_CH < 2) begin : g_bad_num_ch
        $error("bus_rdata_muxn needs at least two channels");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("bus_rdata_muxn TIMEOUT_CYCLES must be positive");
    end

    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_CH - 1);

    state_e                  state_r;
    state_e                  state_nxt_s;
    logic [SEL_W-1:0]        sel_q_r;
    logic [SEL_W-1:0]        sel_clamp_s;
    logic                    cur_valid_s;
    logic                    cur_last_s;
    logic [DATA_WIDTH-1:0]   cur_data_s;
    logic                    sel_ready_s;
    logic                    route_rdy_s;
    logic [NUM_CH-1:0]       in_ready_s;
    logic                    accept_s;
    logic                    timeout_s;
    logic                    push_s;
    logic [DATA_WIDTH-1:0]   push_data_s;
    logic                    push_last_s;
    logic                    pop_s;
    logic [1:0]              count_s;
    logic                    head_valid_s;
    logic [DATA_WIDTH-1:0]   head_data_s;
    logic                    head_last_s;
    logic                    head_err_s;

    // Out-of-range selects fold onto the highest channel.
    always_comb begin
        if (sel > LAST_CH) begin
            sel_clamp_s = LAST_CH;
        end else begin
            sel_clamp_s = sel;
        end
    end

    // Pick the latched channel's valid/last/data out of the packed inputs.
    always_comb begin
        cur_valid_s = 1'b0;
        cur_last_s  = 1'b0;
        cur_data_s  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cur_valid_s = cur_valid_s | (in_valid[i] & (sel_q_r == SEL_W'(i)));
            cur_last_s  = cur_last_s  | (in_last[i]  & (sel_q_r == SEL_W'(i)));
            cur_data_s  = cur_data_s  |
                          (in_data[i*DATA_WIDTH +: DATA_WIDTH] &
                           {DATA_WIDTH{sel_q_r == SEL_W'(i)}});
        end
    end

`ifdef BUS_MUX_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);

    logic [TO_W-1:0] to_cnt_r;

    // Idle-cycle counter: zero outside ROUTE, restarts on every accepted beat, saturates at the limit.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            to_cnt_r <= '0;
        end else if (state_r != ST_ROUTE) begin
            to_cnt_r <= '0;
        end else if (accept_s) begin
            to_cnt_r <= '0;
        end else if (to_cnt_r != TO_LIMIT) begin
            to_cnt_r <= to_cnt_r + TO_W'(1);
        end else begin
            to_cnt_r <= to_cnt_r;
        end
    end

    // The error beat needs a free skid slot, so it waits while the buffer is full.
    assign timeout_s = (state_r == ST_ROUTE) && (to_cnt_r == TO_LIMIT) && (count_s != SKID_DEPTH);
`else
    assign timeout_s = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Select latch, captured only when a new transaction is accepted.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sel_q_r <= '0;
        end else if ((state_r == ST_IDLE) && sel_valid) begin
            sel_q_r <= sel_clamp_s;
        end else begin
            sel_q_r <= sel_q_r;
        end
    end

    // Next-state logic: route until the last beat (or timeout), then drain the skid.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (sel_valid) begin
                    state_nxt_s = ST_ROUTE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ROUTE: begin
                if (timeout_s) begin
                    state_nxt_s = ST_DRAIN;
                end else if (accept_s && cur_last_s) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_ROUTE;
                end
            end
            ST_DRAIN: begin
                if ((count_s == 2'd0) || ((count_s == 2'd1) && pop_s)) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Output decode: select handshake in IDLE, channel ready in ROUTE while the skid has room.
    always_comb begin
        sel_ready_s = 1'b0;
        route_rdy_s = 1'b0;
        case (state_r)
            ST_IDLE:  sel_ready_s = 1'b1;
            ST_ROUTE: route_rdy_s = (count_s != SKID_DEPTH) && !timeout_s;
            ST_DRAIN: route_rdy_s = 1'b0;
            default:  sel_ready_s = 1'b0;
        endcase
        for (int i = 0; i < NUM_CH; i++) begin
            in_ready_s[i] = route_rdy_s && (sel_q_r == SEL_W'(i));
        end
    end

    assign accept_s    = route_rdy_s & cur_valid_s;
    assign push_s      = accept_s | timeout_s;
    assign push_data_s = timeout_s ? {DATA_WIDTH{1'b0}} : cur_data_s;
    assign push_last_s = timeout_s | cur_last_s;
    assign pop_s       = head_valid_s & out_ready;

    mux_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk        (clk),
        .rstn       (rstn),
        .push       (push_s),
        .push_data  (push_data_s),
        .push_last  (push_last_s),
        .push_err   (timeout_s),
        .pop        (pop_s),
        .count      (count_s),
        .head_valid (head_valid_s),
        .head_data  (head_data_s),
        .head_last  (head_last_s),
        .head_err   (head_err_s)
    );

    assign sel_ready = sel_ready_s;
    assign in_ready  = in_ready_s;
    assign out_valid = head_valid_s;
    assign out_data  = head_data_s;
    assign out_last  = head_last_s;
    // Without the timeout feature nothing ever pushes err=1, so this stays 0.
    assign out_err   = head_err_s;

endmodule

// File: tb/tb_bus_rdata_muxn.sv
// Directed, table-driven bench for bus_rdata_muxn (NUM_CH=3, DATA_WIDTH=32).
module tb_bus_rdata_muxn;

    localparam int DW  = 32;
    localparam int NCH = 3;
    localparam int SW  = 2;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic [SW-1:0]     sel = '0;
    logic              sel_valid = 1'b0;
    logic              sel_ready;
    logic [NCH*DW-1:0] in_data = '0;
    logic [NCH-1:0]    in_valid = '0;
    logic [NCH-1:0]    in_last = '0;
    logic [NCH-1:0]    in_ready;
    logic [DW-1:0]     out_data;
    logic              out_valid;
    logic              out_last;
    logic              out_err;
    logic              out_ready = 1'b0;

    int n_pass = 0;
    int n_total = 0;

    bus_rdata_muxn #(
        .DATA_WIDTH     (DW),
        .NUM_CH         (NCH),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .sel       (sel),
        .sel_valid (sel_valid),
        .sel_ready (sel_ready),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_err   (out_err),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  sel;
        int          ch;
        int          n;
        logic [31:0] base;
        int          st_start;
        int          st_len;
        int          exp_tx;
        int          exp_head_off;
        logic        exp_rdy;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_ch(input int c, input logic v, input logic [31:0] d, input logic l);
        in_valid[c] = v;
        in_data[c*DW +: DW] = d;
        in_last[c] = l;
    endtask

    task automatic clear_inputs();
        in_valid = '0;
        in_last  = '0;
        in_data  = '0;
    endtask

    // Present a select and hold it until accepted; returns just after the accepting edge.
    task automatic do_select(input logic [1:0] s);
        @(negedge clk);
        sel = s;
        sel_valid = 1'b1;
        for (int i = 0; i < 20 && !sel_ready; i++) @(negedge clk);
        chk("sel_accept", sel_ready, 1'b1);
        @(posedge clk);
        #1;
        sel_valid = 1'b0;
    endtask

    task automatic run_burst(input vec_t v);
        int tx;
        int rx;
        bit done;
        int noise;
        logic [NCH-1:0] mask;
        tx = 0;
        rx = 0;
        done = 1'b0;
        noise = (v.ch + 1) % NCH;
        mask = '1;
        mask[v.ch] = 1'b0;
        do_select(v.sel);
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            @(negedge clk);
            out_ready = !((cyc >= v.st_start) && (cyc < v.st_start + v.st_len));
            set_ch(noise, 1'b1, 32'hDEAD_0000 + cyc, 1'b0);
            if (tx < v.n) set_ch(v.ch, 1'b1, v.base + tx, (tx == v.n - 1));
            else          set_ch(v.ch, 1'b0, 32'h0, 1'b0);
            chk("noise_ready", in_ready & mask, 0);
            if (v.st_len > 0 && cyc == v.st_start + v.st_len - 1) begin
                chk("stall_accepted", tx, v.exp_tx);
                chk("stall_in_ready", in_ready[v.ch], v.exp_rdy);
                chk("stall_hold_data", out_data, v.base + v.exp_head_off);
            end
            if (out_valid) begin
                chk("beat_data", out_data, v.base + rx);
                chk("beat_last", out_last, (rx == v.n - 1));
                chk("beat_err", out_err, 1'b0);
                if (out_ready) rx++;
            end
            if (in_valid[v.ch] && in_ready[v.ch]) tx++;
            if (rx == v.n) done = 1'b1;
        end
        clear_inputs();
        chk("burst_beats", rx, v.n);
        @(negedge clk);
        chk("burst_idle_selrdy", sel_ready, 1'b1);
        chk("burst_idle_valid", out_valid, 1'b0);
    endtask

    initial begin
        //           sel    ch n  base          st  len tx off rdy
        tbl[0] = '{2'd1, 1, 4, 32'h0000_00A0, 0, 0, 0, 0, 1'b0};
        tbl[1] = '{2'd1, 1, 4, 32'h0000_00A0, 0, 5, 2, 0, 1'b0};
        tbl[2] = '{2'd3, 2, 3, 32'h0000_0030, 0, 0, 0, 0, 1'b0};
        tbl[3] = '{2'd0, 0, 1, 32'h0000_0055, 0, 0, 0, 0, 1'b0};
        tbl[4] = '{2'd2, 2, 6, 32'h0000_1000, 2, 2, 3, 1, 1'b0};
        tbl[5] = '{2'd0, 0, 5, 32'hFFFF_FFF0, 3, 3, 4, 2, 1'b0};

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_last", out_last, 1'b0);
        chk("rst_out_err", out_err, 1'b0);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_sel_ready", sel_ready, 1'b1);
        chk("rst_in_ready", in_ready, 3'b000);
        rstn = 1'b1;

        // Exact one-cycle latency on an unthrottled ch1 burst.
        do_select(2'd1);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            set_ch(1, 1'b1, 32'hA0 + k, (k == 3));
            chk("lat_valid", out_valid, (k > 0));
            if (k > 0) chk("lat_data", out_data, 32'hA0 + k - 1);
            chk("lat_in_ready", in_ready, 3'b010);
        end
        @(negedge clk);
        clear_inputs();
        chk("lat_last_data", out_data, 32'hA3);
        chk("lat_last_flag", out_last, 1'b1);
        chk("lat_drain_selrdy", sel_ready, 1'b0);
        @(negedge clk);
        chk("lat_idle_selrdy", sel_ready, 1'b1);
        chk("lat_idle_valid", out_valid, 1'b0);

        // Reset mid-burst with one beat buffered.
        do_select(2'd1);
        out_ready = 1'b0;
        @(negedge clk);
        set_ch(1, 1'b1, 32'hB0, 1'b0);
        @(negedge clk);
        clear_inputs();
        chk("mid_buffered", out_valid, 1'b1);
        rstn = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 1'b0);
        chk("mid_rst_selrdy", sel_ready, 1'b1);
        chk("mid_rst_in_ready", in_ready, 3'b000);
        chk("mid_rst_data", out_data, 32'h0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("mid_post_valid", out_valid, 1'b0);

        // Table of bursts.
        for (int t = 0; t < 6; t++) begin
            run_burst(tbl[t]);
        end

        // Select presented during DRAIN is held off until the last beat pops.
        do_select(2'd0);
        out_ready = 1'b0;
        @(negedge clk);
        set_ch(0, 1'b1, 32'hC0, 1'b0);
        @(negedge clk);
        set_ch(0, 1'b1, 32'hC1, 1'b1);
        @(negedge clk);
        clear_inputs();
        sel = 2'd2;
        sel_valid = 1'b1;
        chk("drain_selrdy0", sel_ready, 1'b0);
        chk("drain_in_ready", in_ready, 3'b000);
        @(negedge clk);
        out_ready = 1'b1;
        chk("drain_selrdy1", sel_ready, 1'b0);
        chk("drain_head0", out_data, 32'hC0);
        @(negedge clk);
        chk("drain_selrdy2", sel_ready, 1'b0);
        chk("drain_head1", out_data, 32'hC1);
        chk("drain_last1", out_last, 1'b1);
        @(negedge clk);
        chk("drain_idle_selrdy", sel_ready, 1'b1);
        chk("drain_idle_valid", out_valid, 1'b0);
        @(posedge clk);
        #1;
        sel_valid = 1'b0;
        @(negedge clk);
        chk("new_sel_routed", in_ready, 3'b100);
        set_ch(2, 1'b1, 32'hC2, 1'b1);
        @(negedge clk);
        clear_inputs();
        chk("new_sel_data", out_data, 32'hC2);
        chk("new_sel_last", out_last, 1'b1);
        @(negedge clk);
        chk("new_sel_idle", sel_ready, 1'b1);

`ifdef BUS_MUX_TIMEOUT_EN
        // Silent channel: error beat after the idle limit.
        begin
            int seen;
            seen = -1;
            do_select(2'd1);
            out_ready = 1'b1;
            for (int k = 0; k < 20 && seen < 0; k++) begin
                @(negedge clk);
                if (out_valid) seen = k;
            end
            chk("to_cycle", seen, 9);
            chk("to_err", out_err, 1'b1);
            chk("to_last", out_last, 1'b1);
            chk("to_data", out_data, 32'h0);
            @(negedge clk);
            chk("to_idle", sel_ready, 1'b1);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
